// File: rtl/coeff_token_pkg.sv
// Shared Num-VLC1 (2 <= nC < 4) coeff_token codeword table and widths.
// The encoder LUT and the serial decoder both read these constants.
package coeff_token_pkg;

  localparam int MAX_LEN = 14;
  localparam int LEN_W   = 4;
  localparam int TC_W    = 5;
  localparam int T1_W    = 2;
  localparam int NUM_CW  = 62;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] val;
    logic [T1_W-1:0]    t1;
    logic [TC_W-1:0]    tc;
  } cw_t;

  // {length, codeword value right-aligned, TrailingOnes, TotalCoeff}
  localparam cw_t VLC1_TAB [NUM_CW] = '{
    '{4'd2,  14'd3,  2'd0, 5'd0},
    '{4'd6,  14'd11, 2'd0, 5'd1},  '{4'd2,  14'd2,  2'd1, 5'd1},
    '{4'd6,  14'd7,  2'd0, 5'd2},  '{4'd5,  14'd7,  2'd1, 5'd2},  '{4'd3,  14'd3,  2'd2, 5'd2},
    '{4'd7,  14'd7,  2'd0, 5'd3},  '{4'd6,  14'd10, 2'd1, 5'd3},  '{4'd6,  14'd9,  2'd2, 5'd3},  '{4'd4,  14'd5,  2'd3, 5'd3},
    '{4'd8,  14'd7,  2'd0, 5'd4},  '{4'd6,  14'd6,  2'd1, 5'd4},  '{4'd6,  14'd5,  2'd2, 5'd4},  '{4'd4,  14'd4,  2'd3, 5'd4},
    '{4'd8,  14'd4,  2'd0, 5'd5},  '{4'd7,  14'd6,  2'd1, 5'd5},  '{4'd7,  14'd5,  2'd2, 5'd5},  '{4'd5,  14'd6,  2'd3, 5'd5},
    '{4'd9,  14'd7,  2'd0, 5'd6},  '{4'd8,  14'd6,  2'd1, 5'd6},  '{4'd8,  14'd5,  2'd2, 5'd6},  '{4'd6,  14'd8,  2'd3, 5'd6},
    '{4'd11, 14'd15, 2'd0, 5'd7},  '{4'd9,  14'd6,  2'd1, 5'd7},  '{4'd9,  14'd5,  2'd2, 5'd7},  '{4'd6,  14'd4,  2'd3, 5'd7},
    '{4'd11, 14'd11, 2'd0, 5'd8},  '{4'd11, 14'd14, 2'd1, 5'd8},  '{4'd11, 14'd13, 2'd2, 5'd8},  '{4'd7,  14'd4,  2'd3, 5'd8},
    '{4'd12, 14'd15, 2'd0, 5'd9},  '{4'd11, 14'd10, 2'd1, 5'd9},  '{4'd11, 14'd9,  2'd2, 5'd9},  '{4'd9,  14'd4,  2'd3, 5'd9},
    '{4'd12, 14'd11, 2'd0, 5'd10}, '{4'd12, 14'd14, 2'd1, 5'd10}, '{4'd12, 14'd13, 2'd2, 5'd10}, '{4'd11, 14'd12, 2'd3, 5'd10},
    '{4'd12, 14'd8,  2'd0, 5'd11}, '{4'd12, 14'd10, 2'd1, 5'd11}, '{4'd12, 14'd9,  2'd2, 5'd11}, '{4'd11, 14'd8,  2'd3, 5'd11},
    '{4'd13, 14'd15, 2'd0, 5'd12}, '{4'd13, 14'd14, 2'd1, 5'd12}, '{4'd13, 14'd13, 2'd2, 5'd12}, '{4'd12, 14'd12, 2'd3, 5'd12},
    '{4'd13, 14'd11, 2'd0, 5'd13}, '{4'd13, 14'd10, 2'd1, 5'd13}, '{4'd13, 14'd9,  2'd2, 5'd13}, '{4'd13, 14'd12, 2'd3, 5'd13},
    '{4'd13, 14'd7,  2'd0, 5'd14}, '{4'd14, 14'd11, 2'd1, 5'd14}, '{4'd13, 14'd6,  2'd2, 5'd14}, '{4'd13, 14'd8,  2'd3, 5'd14},
    '{4'd14, 14'd9,  2'd0, 5'd15}, '{4'd14, 14'd8,  2'd1, 5'd15}, '{4'd14, 14'd10, 2'd2, 5'd15}, '{4'd13, 14'd1,  2'd3, 5'd15},
    '{4'd14, 14'd7,  2'd0, 5'd16}, '{4'd14, 14'd6,  2'd1, 5'd16}, '{4'd14, 14'd5,  2'd2, 5'd16}, '{4'd14, 14'd4,  2'd3, 5'd16}
  };

endpackage

// File: rtl/coeff_token_vlc1_decoder_if.sv
// Bit-in / token-out handshake bundle of the coeff_token Num-VLC1 decoder.
interface coeff_token_vlc1_if;
  import coeff_token_pkg::*;

  logic              clear;
  logic              bit_valid;
  logic              bit_in;
  logic              bit_ready;
  logic              token_valid;
  logic              token_ready;
  logic [T1_W-1:0]   trailing_ones;
  logic [TC_W-1:0]   total_coeff;
  logic [LEN_W-1:0]  code_len;
  logic              token_err;

  modport master (
    output clear, bit_valid, bit_in, token_ready,
    input  bit_ready, token_valid, trailing_ones, total_coeff, code_len, token_err
  );

  modport slave (
    input  clear, bit_valid, bit_in, token_ready,
    output bit_ready, token_valid, trailing_ones, total_coeff, code_len, token_err
  );

endinterface

// File: rtl/coeff_token_vlc1_decoder_match.sv
// Combinational lookup: does the low `length` bits of `window` form a Num-VLC1 codeword?
module coeff_token_vlc1_match
  import coeff_token_pkg::*;
(
  input  logic [MAX_LEN-1:0] window,
  input  logic [LEN_W-1:0]   length,
  output logic               hit,
  output logic [T1_W-1:0]    t1s,
  output logic [TC_W-1:0]    total_coeff
);

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] win_masked;

  // Keys {length, value} are unique, so at most one entry can fire.
  always_comb begin
    mask        = ~({MAX_LEN{1'b1}} << length);
    win_masked  = window & mask;
    hit         = 1'b0;
    t1s         = '0;
    total_coeff = '0;
    for (int i = 0; i < NUM_CW; i++) begin
      if ({VLC1_TAB[i].len, VLC1_TAB[i].val} == {length, win_masked}) begin
        hit         = 1'b1;
        t1s         = VLC1_TAB[i].t1;
        total_coeff = VLC1_TAB[i].tc;
      end
    end
  end

endmodule

// File: rtl/coeff_token_vlc1_decoder.sv
// Serial coeff_token decoder for the 2 <= nC < 4 table: one bit per cycle in,
// one (T1s, TotalCoeff, length) token out per codeword.
module coeff_token_vlc1_decoder
  import coeff_token_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  coeff_token_vlc1_if.slave tif
);

  dec_state_t         state_q, state_d;
  logic [MAX_LEN-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [T1_W-1:0]    t1_q, t1_d;
  logic [TC_W-1:0]    tc_q, tc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               err_q, err_d;

  logic               accept;
  logic [MAX_LEN-1:0] win;
  logic [LEN_W-1:0]   len1;
  logic               m_hit;
  logic [T1_W-1:0]    m_t1;
  logic [TC_W-1:0]    m_tc;

  assign tif.bit_ready     = (state_q == COLLECT) || tif.token_ready;
  assign tif.token_valid   = (state_q == HOLD);
  assign tif.trailing_ones = t1_q;
  assign tif.total_coeff   = tc_q;
  assign tif.code_len      = len_q;
  assign tif.token_err     = err_q;

  assign accept = tif.bit_valid && tif.bit_ready;
  assign win    = {sr_q[MAX_LEN-2:0], tif.bit_in};
  assign len1   = cnt_q + 1'b1;

  coeff_token_vlc1_match u_match (
    .window      (win),
    .length      (len1),
    .hit         (m_hit),
    .t1s         (m_t1),
    .total_coeff (m_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      t1_q    <= '0;
      tc_q    <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      t1_q    <= t1_d;
      tc_q    <= tc_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // sr/cnt are already zero in HOLD, so a bit taken during the token handoff
  // naturally starts a fresh codeword through the same path.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    t1_d    = t1_q;
    tc_d    = tc_q;
    len_d   = len_q;
    err_d   = err_q;
    if (tif.clear) begin
      state_d = COLLECT;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      if (state_q == HOLD && tif.token_ready) state_d = COLLECT;
      if (accept) begin
        if (m_hit) begin
          state_d = HOLD;
          sr_d    = '0;
          cnt_d   = '0;
          t1_d    = m_t1;
          tc_d    = m_tc;
          len_d   = len1;
          err_d   = 1'b0;
        end else if (len1 == LEN_W'(MAX_LEN)) begin
          state_d = HOLD;
          sr_d    = '0;
          cnt_d   = '0;
          t1_d    = '0;
          tc_d    = '0;
          len_d   = len1;
          err_d   = 1'b1;
        end else begin
          sr_d  = win;
          cnt_d = len1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coeff_token_vlc1_decoder.sv
// Directed bench for coeff_token_vlc1_decoder with a queue scoreboard and independent monitor.
module tb_coeff_token_vlc1_decoder;
  import coeff_token_pkg::*;

  typedef struct packed {
    logic [1:0] t1;
    logic [4:0] tc;
    logic [3:0] len;
    logic       err;
  } tok_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coeff_token_vlc1_if tif();

  coeff_token_vlc1_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif.slave)
  );

  tok_t exp_q[$];
  tok_t mon_got, mon_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int t1, input int tc, input int len, input int err);
    tok_t e;
    e.t1 = 2'(t1); e.tc = 5'(tc); e.len = 4'(len); e.err = 1'(err);
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    int   guard = 0;
    logic rdy;
    do begin
      @(negedge clk);
      tif.bit_valid = 1'b1;
      tif.bit_in    = b;
      #1;
      rdy = tif.bit_ready;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) check("bit_accept_timeout", 0, 1);
  endtask

  task automatic send_code(input string s);
    for (int i = 0; i < s.len(); i++) send_bit(s[i] == "1");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tif.bit_valid = 1'b0;
    end
  endtask

  // Monitor: every handshaken token is compared against the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && tif.token_valid && tif.token_ready) begin
        mon_got = '{tif.trailing_ones, tif.total_coeff, tif.code_len, tif.token_err};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_token: got t1=%0d tc=%0d len=%0d err=%0d, required none",
                   mon_got.t1, mon_got.tc, mon_got.len, mon_got.err);
        end else begin
          mon_exp = exp_q.pop_front();
          check("tok_t1",  int'(mon_got.t1),  int'(mon_exp.t1));
          check("tok_tc",  int'(mon_got.tc),  int'(mon_exp.tc));
          check("tok_len", int'(mon_got.len), int'(mon_exp.len));
          check("tok_err", int'(mon_got.err), int'(mon_exp.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tif.clear       = 1'b0;
    tif.bit_valid   = 1'b0;
    tif.bit_in      = 1'b0;
    tif.token_ready = 1'b1;
    #12;
    check("rst_token_valid", tif.token_valid, 0);
    check("rst_t1",          tif.trailing_ones, 0);
    check("rst_tc",          tif.total_coeff, 0);
    check("rst_len",         tif.code_len, 0);
    check("rst_err",         tif.token_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_bit_ready", tif.bit_ready, 1);

    // First codeword and its one-cycle latency
    push(0, 0, 2, 0);
    send_code("11");
    @(negedge clk);
    tif.bit_valid = 1'b0;
    #1;
    check("latency_valid", tif.token_valid, 1);
    idle(2);

    // Back-to-back short codewords
    push(1, 1, 2, 0); push(2, 2, 3, 0); push(3, 3, 4, 0);
    send_code("10"); send_code("011"); send_code("0101");
    idle(2);

    // Longest codewords
    push(3, 15, 13, 0); push(3, 16, 14, 0); push(0, 16, 14, 0);
    send_code("0000000000001");
    send_code("00000000000100");
    send_code("00000000000111");
    idle(2);

    // Backpressure, then release together with the next codeword's first bit
    @(negedge clk);
    tif.token_ready = 1'b0;
    push(0, 1, 6, 0);
    send_code("001011");
    repeat (5) begin
      @(negedge clk);
      tif.bit_valid = 1'b0;
      #1;
      check("bp_valid",     tif.token_valid, 1);
      check("bp_t1",        tif.trailing_ones, 0);
      check("bp_tc",        tif.total_coeff, 1);
      check("bp_len",       tif.code_len, 6);
      check("bp_err",       tif.token_err, 0);
      check("bp_bit_ready", tif.bit_ready, 0);
    end
    push(1, 1, 2, 0);
    @(negedge clk);
    tif.token_ready = 1'b1;
    tif.bit_valid   = 1'b1;
    tif.bit_in      = 1'b1;
    #1;
    check("release_bit_ready", tif.bit_ready, 1);
    @(posedge clk);
    send_bit(1'b0);
    idle(2);

    // Fourteen zeros form no codeword
    push(0, 0, 14, 1);
    send_code("00000000000000");
    push(0, 0, 2, 0);
    send_code("11");
    idle(2);

    // clear mid-codeword; the bit offered in the clear cycle must be dropped
    send_code("0000");
    @(negedge clk);
    tif.clear     = 1'b1;
    tif.bit_valid = 1'b1;
    tif.bit_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tif.clear     = 1'b0;
    tif.bit_valid = 1'b0;
    #1;
    check("clear_no_token", tif.token_valid, 0);
    push(1, 1, 2, 0);
    send_code("10");
    idle(2);

    // Asynchronous reset mid-codeword
    send_code("0000");
    @(negedge clk);
    tif.bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("areset_no_token", tif.token_valid, 0);
    #2;
    rst_n = 1'b1;
    push(1, 1, 2, 0);
    send_code("10");
    idle(4);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
